// File: rtl/knap_search_ctrl.sv
// Exhaustive knapsack search sequencer: enumerates every item-selection mask and keeps the best feasible one.
// Optional result streaming with backpressure is built when KNAP_STREAM_EN is defined.
module knap_search_ctrl #(
    parameter  int N_ITEMS = 7,
    parameter  int VW      = 6,
    localparam int SW      = VW + $clog2(N_ITEMS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [N_ITEMS*VW-1:0] item_value,
    input  logic [N_ITEMS*VW-1:0] item_weight,
    input  logic [SW-1:0]         min_value,
    input  logic [SW-1:0]         max_weight,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic [N_ITEMS-1:0]    best_mask,
    output logic [SW-1:0]         best_value,
    output logic [SW-1:0]         best_weight,
    output logic [N_ITEMS:0]      valid_count,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_ITEMS-1:0]    out_mask,
    output logic [SW-1:0]         out_value
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [N_ITEMS-1:0] MASK_LAST = '1;
    localparam logic [N_ITEMS-1:0] MASK_ONE  = 1;
    localparam logic [N_ITEMS:0]   CNT_ONE   = 1;

    logic [1:0]            r_state;
    logic                  r_launch;
    logic                  r_done;
    logic [N_ITEMS-1:0]    r_mask;
    logic [N_ITEMS*VW-1:0] r_item_value;
    logic [N_ITEMS*VW-1:0] r_item_weight;
    logic [SW-1:0]         r_min_value;
    logic [SW-1:0]         r_max_weight;
    logic                  r_found;
    logic [N_ITEMS-1:0]    r_best_mask;
    logic [SW-1:0]         r_best_value;
    logic [SW-1:0]         r_best_weight;
    logic [N_ITEMS:0]      r_valid_count;

    logic [SW-1:0]         w_sum_value;
    logic [SW-1:0]         w_sum_weight;
    logic                  w_feasible;
    logic                  w_better;
    logic                  w_accept_start;
    logic                  w_abort;
    logic                  w_stall;
    logic                  w_step;

    // NOTE: every always_comb output gets a default before the loop so no latch is inferred.
    always_comb begin
        w_sum_value  = '0;
        w_sum_weight = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (r_mask[i]) begin
                w_sum_value  = w_sum_value  + SW'(r_item_value[i*VW +: VW]);
                w_sum_weight = w_sum_weight + SW'(r_item_weight[i*VW +: VW]);
            end
        end
    end

    assign w_feasible = (w_sum_value >= r_min_value) && (w_sum_weight <= r_max_weight);

    // A full tie keeps the incumbent, which is always the lower mask.
    assign w_better = !r_found
                   || (w_sum_value > r_best_value)
                   || ((w_sum_value == r_best_value) && (w_sum_weight < r_best_weight));

    // Start is refused during the launch cycle and the done cycle.
    assign w_accept_start = (r_state == S_IDLE) && start && !r_launch && !r_done;
    assign w_abort        = abort && (r_state != S_IDLE);

`ifdef KNAP_STREAM_EN
    logic                  r_s1_valid;
    logic [N_ITEMS-1:0]    r_s1_mask;
    logic [SW-1:0]         r_s1_value;

    assign w_stall = r_s1_valid && !out_ready;
`else
    logic                  w_unused_ready;

    assign w_unused_ready = out_ready;
    assign w_stall        = 1'b0;
`endif

    assign w_step = (r_state == S_RUN) && !w_stall && !w_abort;

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_launch      <= 1'b0;
            r_done        <= 1'b0;
            r_mask        <= '0;
            // NOTE: the latched item tables are small registers, so they are reset like all other state.
            r_item_value  <= '0;
            r_item_weight <= '0;
            r_min_value   <= '0;
            r_max_weight  <= '0;
            r_found       <= 1'b0;
            r_best_mask   <= '0;
            r_best_value  <= '0;
            r_best_weight <= '0;
            r_valid_count <= '0;
        end else begin
            r_done   <= 1'b0;
            r_launch <= 1'b0;

            if (w_accept_start) begin
                r_launch      <= 1'b1;
                r_mask        <= '0;
                r_item_value  <= item_value;
                r_item_weight <= item_weight;
                r_min_value   <= min_value;
                r_max_weight  <= max_weight;
                r_found       <= 1'b0;
                r_best_mask   <= '0;
                r_best_value  <= '0;
                r_best_weight <= '0;
                r_valid_count <= '0;
            end

            if (r_launch) begin
                r_state <= S_RUN;
            end

            if (w_abort) begin
                r_state <= S_IDLE;
            end else if (w_step) begin
                if (w_feasible) begin
                    r_valid_count <= r_valid_count + CNT_ONE;
                    r_found       <= 1'b1;
                    if (w_better) begin
                        r_best_mask   <= r_mask;
                        r_best_value  <= w_sum_value;
                        r_best_weight <= w_sum_weight;
                    end
                end
                r_mask <= r_mask + MASK_ONE;
                if (r_mask == MASK_LAST) begin
                    r_state <= S_DRAIN;
                end
            end else if ((r_state == S_DRAIN) && !w_stall) begin
                r_done  <= 1'b1;
                r_state <= S_IDLE;
            end
        end
    end

`ifdef KNAP_STREAM_EN
    // Stage 1 reloads on every advance; a held entry is dropped once the consumer takes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_mask  <= '0;
            r_s1_value <= '0;
        end else if (w_abort) begin
            r_s1_valid <= 1'b0;
        end else if (w_step) begin
            r_s1_valid <= w_feasible;
            r_s1_mask  <= r_mask;
            r_s1_value <= w_sum_value;
        end else if (r_s1_valid && out_ready) begin
            r_s1_valid <= 1'b0;
        end
    end

    assign out_valid = r_s1_valid;
    assign out_mask  = r_s1_mask;
    assign out_value = r_s1_value;
`else
    assign out_valid = 1'b0;
    assign out_mask  = '0;
    assign out_value = '0;
`endif

    assign busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done        = r_done;
    assign found       = r_found;
    assign best_mask   = r_best_mask;
    assign best_value  = r_best_value;
    assign best_weight = r_best_weight;
    assign valid_count = r_valid_count;

endmodule

// File: tb/tb_knap_search_ctrl.sv
// Directed bench for knap_search_ctrl: search results, completion timing, abort, reset and streaming.
module tb_knap_search_ctrl;

    localparam int N  = 7;
    localparam int VW = 6;
    localparam int SW = 9;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            abort;
    logic [N*VW-1:0] item_value;
    logic [N*VW-1:0] item_weight;
    logic [SW-1:0]   min_value;
    logic [SW-1:0]   max_weight;
    logic            busy;
    logic            done;
    logic            found;
    logic [N-1:0]    best_mask;
    logic [SW-1:0]   best_value;
    logic [SW-1:0]   best_weight;
    logic [N:0]      valid_count;
    logic            out_valid;
    logic            out_ready;
    logic [N-1:0]    out_mask;
    logic [SW-1:0]   out_value;

    knap_search_ctrl #(.N_ITEMS(N), .VW(VW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .item_value (item_value),
        .item_weight(item_weight),
        .min_value  (min_value),
        .max_weight (max_weight),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .best_mask  (best_mask),
        .best_value (best_value),
        .best_weight(best_weight),
        .valid_count(valid_count),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mask   (out_mask),
        .out_value  (out_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Case 1 tables: values 4,2,2,1,10,12,10 and weights 12,1,2,1,4,2,2 for items 0..6.
    localparam logic [N*VW-1:0] C1_VAL = {6'd10, 6'd12, 6'd10, 6'd1, 6'd2, 6'd2, 6'd4};
    localparam logic [N*VW-1:0] C1_WGT = {6'd2, 6'd2, 6'd4, 6'd1, 6'd2, 6'd1, 6'd12};
    localparam logic [N*VW-1:0] ONES   = {7{6'd1}};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},        32'(busy),        0);
        chk({tag, "_done"},        32'(done),        0);
        chk({tag, "_found"},       32'(found),       0);
        chk({tag, "_best_mask"},   32'(best_mask),   0);
        chk({tag, "_best_value"},  32'(best_value),  0);
        chk({tag, "_best_weight"}, 32'(best_weight), 0);
        chk({tag, "_valid_count"}, 32'(valid_count), 0);
        chk({tag, "_out_valid"},   32'(out_valid),   0);
        chk({tag, "_out_mask"},    32'(out_mask),    0);
        chk({tag, "_out_value"},   32'(out_value),   0);
    endtask

    // Brute-force reference over masks 0..lim.
    function automatic void ref_eval(input logic [N*VW-1:0] v, input logic [N*VW-1:0] w,
                                     input int mn, input int mx, input int lim,
                                     output int cnt, output int bm, output int bv, output int bw);
        int sv;
        int sw;
        cnt = 0; bm = 0; bv = 0; bw = 0;
        for (int m = 0; m <= lim; m++) begin
            sv = 0;
            sw = 0;
            for (int i = 0; i < N; i++) begin
                if (m[i]) begin
                    sv += int'(v[i*VW +: VW]);
                    sw += int'(w[i*VW +: VW]);
                end
            end
            if (sv >= mn && sw <= mx) begin
                if (cnt == 0 || sv > bv || (sv == bv && sw < bw)) begin
                    bm = m; bv = sv; bw = sw;
                end
                cnt++;
            end
        end
    endfunction

    // Caller raises start before the next edge (edge 0). Edge numbers count from there.
    task automatic run_search(input int abort_edge, input int rst_edge, input int stall_len,
                              output int done_edge, output int accepted, output int ov_seen,
                              output bit stable);
        int           stall_left;
        bit           first;
        logic [N-1:0] held;
        done_edge = -1; accepted = 0; ov_seen = 0; stable = 1'b1;
        stall_left = 0; first = 1'b1; held = '0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_edge0", 32'(busy), 0);
        for (int e = 1; e <= 400; e++) begin
            @(posedge clk); #1;
            if (e == 1) chk("busy_after_edge1", 32'(busy), 1);
            if (abort_edge >= 0 && e == abort_edge + 1) begin
                abort = 1'b0;
                chk("abort_busy", 32'(busy), 0);
                chk("abort_no_done", 32'(done), 0);
                chk("abort_out_valid", 32'(out_valid), 0);
                break;
            end
            if (rst_edge >= 0 && e == rst_edge) begin
                check_reset_outputs("mid_rst");
                break;
            end
            if (done) begin
                done_edge = e;
                chk("done_busy_low", 32'(busy), 0);
                break;
            end
            if (e == abort_edge) abort = 1'b1;
            if (rst_edge >= 0 && e == rst_edge - 1) rst_n = 1'b0;
            if (out_valid) ov_seen++;
            if (out_valid && first && stall_len > 0) begin
                first = 1'b0;
                stall_left = stall_len;
                held = out_mask;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
                if (out_mask !== held || out_valid !== 1'b1) stable = 1'b0;
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) accepted++;
        end
        out_ready = 1'b1;
    endtask

    task automatic check_case1(input string tag, input int de);
        chk({tag, "_done_edge"},   32'(de),          130);
        chk({tag, "_found"},       32'(found),       1);
        chk({tag, "_best_mask"},   32'(best_mask),   32'h7E);
        chk({tag, "_best_value"},  32'(best_value),  37);
        chk({tag, "_best_weight"}, 32'(best_weight), 12);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        chk("done_single_cycle", 32'(done), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int de, acc, ovs;
    bit stab;
    int rc, rbm, rbv, rbw;
    int done_seen;

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        item_value = '0; item_weight = '0; min_value = '0; max_weight = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Case 1: nominal search.
        item_value = C1_VAL; item_weight = C1_WGT; min_value = 9'd15; max_weight = 9'd16;
        ref_eval(C1_VAL, C1_WGT, 15, 16, 127, rc, rbm, rbv, rbw);
        start = 1'b1;
        run_search(-1, -1, 0, de, acc, ovs, stab);
        check_case1("c1", de);
        chk("c1_valid_count", 32'(valid_count), 32'(rc));
`ifdef KNAP_STREAM_EN
        chk("c1_accepted", 32'(acc), 32'(rc));
`else
        chk("c1_no_stream", 32'(ovs), 0);
`endif
        idle_cycle();
        chk("c1_results_hold", 32'(best_mask), 32'h7E);

        // Case 2: value threshold unreachable.
        min_value = 9'd63;
        start = 1'b1;
        run_search(-1, -1, 0, de, acc, ovs, stab);
        chk("c2_done_edge",   32'(de),          130);
        chk("c2_found",       32'(found),       0);
        chk("c2_valid_count", 32'(valid_count), 0);
        chk("c2_best_mask",   32'(best_mask),   0);
        chk("c2_best_value",  32'(best_value),  0);
        chk("c2_best_weight", 32'(best_weight), 0);
        chk("c2_out_valid_seen", 32'(ovs), 0);

        // Back-to-back: start during the done cycle is refused, next cycle is taken.
        item_value = ONES; item_weight = ONES; min_value = 9'd0; max_weight = 9'd0;
        start = 1'b1;
        @(posedge clk); #1;
        chk("b2b_start_ignored", 32'(busy), 0);
        chk("b2b_done_dropped", 32'(done), 0);

        // Case 3: only the empty selection fits.
        run_search(-1, -1, 0, de, acc, ovs, stab);
        chk("c3_done_edge",   32'(de),          130);
        chk("c3_found",       32'(found),       1);
        chk("c3_valid_count", 32'(valid_count), 1);
        chk("c3_best_mask",   32'(best_mask),   0);
        chk("c3_best_value",  32'(best_value),  0);
        idle_cycle();

        // Case 4: consumer stalls for 10 cycles on the first streamed entry.
        item_value = C1_VAL; item_weight = C1_WGT; min_value = 9'd15; max_weight = 9'd16;
        start = 1'b1;
        run_search(-1, -1, 10, de, acc, ovs, stab);
`ifdef KNAP_STREAM_EN
        chk("c4_done_edge", 32'(de), 140);
        chk("c4_mask_stable", 32'(stab), 1);
        chk("c4_accepted", 32'(acc), 32'(rc));
`else
        chk("c4_done_edge", 32'(de), 130);
        chk("c4_no_stream", 32'(ovs), 0);
`endif
        chk("c4_found",       32'(found),       1);
        chk("c4_best_mask",   32'(best_mask),   32'h7E);
        chk("c4_best_value",  32'(best_value),  37);
        chk("c4_best_weight", 32'(best_weight), 12);
        chk("c4_valid_count", 32'(valid_count), 32'(rc));
        idle_cycle();

        // Case 5: abort sampled at edge 51 keeps results of masks 0..48.
        start = 1'b1;
        run_search(50, -1, 0, de, acc, ovs, stab);
        ref_eval(C1_VAL, C1_WGT, 15, 16, 48, rc, rbm, rbv, rbw);
        chk("abort_partial_count", 32'(valid_count), 32'(rc));
        chk("abort_partial_mask",  32'(best_mask),   32'(rbm));
        chk("abort_partial_value", 32'(best_value),  32'(rbv));
        done_seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        chk("abort_never_done", 32'(done_seen), 0);
        ref_eval(C1_VAL, C1_WGT, 15, 16, 127, rc, rbm, rbv, rbw);
        start = 1'b1;
        run_search(-1, -1, 0, de, acc, ovs, stab);
        check_case1("c5_rerun", de);
        chk("c5_rerun_valid_count", 32'(valid_count), 32'(rc));
        idle_cycle();

        // Case 6: synchronous reset at edge 60, start held while reset is low.
        start = 1'b1;
        run_search(-1, 60, 0, de, acc, ovs, stab);
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start_ignored", 32'(busy), 0);
        rst_n = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("rst_idle_after_release", 32'(busy), 0);
        start = 1'b1;
        run_search(-1, -1, 0, de, acc, ovs, stab);
        check_case1("c6_rerun", de);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
